// File: rtl/mpadd16_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
//   LIMB_W  : width of one operand limb
//   state_t : sequencer state (IDLE waits for limb 0, CHAIN is mid-operation)
//   OP_SUB  : value of in_sub that selects A-B
package mpadd16_pkg;

  localparam int LIMB_W = 16;

  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHAIN = 1'b1
  } state_t;

endpackage

// File: rtl/mpadd16_seq_adder16.sv
// adder16: combinational 16-bit adder with carry in/out.
// Ports:
//   a, b  in  16  addends
//   cin   in  1   carry in
//   sum   out 16  a + b + cin (low 16 bits)
//   cout  out 1   carry out of bit 15
module adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};

endmodule

// File: rtl/mpadd16_seq.sv
// mpadd16_seq: multi-precision add/subtract sequencer around adder16.
// Operand limbs arrive least-significant first on a valid/ready stream; the
// inter-limb carry is kept in a register, and each result limb leaves through
// a single output register stage with index, last, carry-out and overflow.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input limb handshake
//   in_x, in_y            operand A / B limb
//   in_sub                1 = A-B, 0 = A+B (sampled on limb 0 only)
//   out_valid/out_ready   output limb handshake
//   out_sum, out_idx      result limb and its index
//   out_last              result limb is the most significant one
//   out_cout, out_ovf     final carry / signed overflow (meaningful with out_last)
//   busy                  an operation is mid-chain
module mpadd16_seq
  import mpadd16_pkg::*;
#(
  parameter int NWORDS = 4,
  parameter int IDXW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_x,
  input  logic [15:0]       in_y,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_sum,
  output logic [IDXW-1:0]   out_idx,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_ovf,
  output logic              busy
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic              r_sub;

  logic              w_accept;
  logic              w_first;
  logic              w_is_last;
  logic              w_sub_eff;
  logic              w_cin;
  logic [LIMB_W-1:0] w_y;
  logic [LIMB_W-1:0] w_sum;
  logic              w_cout;
  logic              w_ovf;

  // The output register can take a new limb when empty or being drained now.
  assign in_ready  = ~out_valid | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_first   = (r_idx == '0);
  assign w_is_last = (r_idx == LAST_IDX);

  // Subtraction is A + ~B + 1: the +1 enters as carry-in of limb 0 only.
  assign w_sub_eff = ((w_first ? in_sub : r_sub) == OP_SUB);
  assign w_y       = in_y ^ {LIMB_W{w_sub_eff}};
  assign w_cin     = w_first ? w_sub_eff : r_carry;

  adder16 u_adder16 (
    .a    (in_x),
    .b    (w_y),
    .cin  (w_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Overflow uses the inverted B limb, so one rule covers add and subtract.
  assign w_ovf = (in_x[LIMB_W-1] == w_y[LIMB_W-1]) & (w_sum[LIMB_W-1] != in_x[LIMB_W-1]);

  assign busy = (r_state == ST_CHAIN);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)              w_state_nxt = ST_CHAIN;
      ST_CHAIN: if (w_accept && w_is_last) w_state_nxt = ST_IDLE;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_sub     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (w_first) r_sub <= in_sub;
        r_carry   <= w_cout;
        r_idx     <= w_is_last ? '0 : r_idx + 1'b1;
        out_valid <= 1'b1;
        out_sum   <= w_sum;
        out_idx   <= r_idx;
        out_last  <= w_is_last;
        out_cout  <= w_is_last & w_cout;
        out_ovf   <= w_is_last & w_ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mpadd16_seq.sv
module tb_mpadd16_seq;

  localparam int NW = 4;
  localparam int W  = 16 * NW;

  typedef struct {
    logic [15:0] sum;
    logic [1:0]  idx;
    logic        last;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   stall_cycles = 0;
  bit   rnd_bp = 0;
  exp_t expq[$];
  int   acc_log[$];

  bit          prev_stall = 0;
  logic [15:0] prev_sum;
  logic [1:0]  prev_idx;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  mpadd16_seq #(.NWORDS(NW), .IDXW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Downstream readiness: forced stalls first, otherwise random or always-ready.
  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #2;
    if (stall_cycles > 0) begin
      out_ready = 1'b0;
      stall_cycles--;
    end else begin
      out_ready = rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      n_acc      = 0;
      prev_stall = 0;
    end else begin
      check_val("busy", busy, (n_acc % NW) != 0);
      check_val("in_ready", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_sum", out_sum, prev_sum);
        check_val("hold_idx", out_idx, prev_idx);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check_val("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check_val("sum", out_sum, e.sum);
          check_val("idx", out_idx, e.idx);
          check_val("last", out_last, e.last);
          check_val("cout", out_cout, e.cout);
          check_val("ovf", out_ovf, e.ovf);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = out_sum;
      prev_idx   = out_idx;
      if (in_valid && in_ready) n_acc++;
    end
  end

  // Whole-operand reference: the result is plain wide arithmetic, split into limbs.
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input int nlimbs, input int stall_after, input bit gaps);
    logic [W:0]   r;
    logic [W-1:0] res;
    logic         cout, ovf;
    if (sub) r = {1'b0, a} - {1'b0, b} + {1'b1, {W{1'b0}}};
    else     r = {1'b0, a} + {1'b0, b};
    res  = r[W-1:0];
    cout = r[W];
    if (sub) ovf = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
    else     ovf = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
    for (int i = 0; i < nlimbs; i++) begin
      bit acc;
      int waited;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_x     = 16'($urandom);
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_x     = a[16*i +: 16];
      in_y     = b[16*i +: 16];
      in_sub   = (i == 0) ? sub : 1'($urandom_range(0, 1));
      acc      = 0;
      waited   = 0;
      while (!acc) begin
        @(negedge clk);
        if (in_ready) begin
          exp_t e;
          acc    = 1;
          e.sum  = res[16*i +: 16];
          e.idx  = 2'(i);
          e.last = (i == NW - 1);
          e.cout = (i == NW - 1) ? cout : 1'b0;
          e.ovf  = (i == NW - 1) ? ovf : 1'b0;
          expq.push_back(e);
          acc_log.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (!acc) begin
          waited++;
          if (waited > 50) begin
            check_val("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
          end
        end
      end
      if (i == stall_after) stall_cycles = 3;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_out_sum"}, out_sum, 0);
    check_val({tag, "_out_idx"}, out_idx, 0);
    check_val({tag, "_out_last"}, out_last, 0);
    check_val({tag, "_out_cout"}, out_cout, 0);
    check_val({tag, "_out_ovf"}, out_ovf, 0);
    check_val({tag, "_busy"}, busy, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_val("drain", expq.size(), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_x     = 16'h0;
    in_y     = 16'h0;
    in_sub   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_init");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Carry ripple into limb 1, all-ones wrap, and signed overflow on subtract.
    send_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, NW, -1, 0);
    send_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, NW, -1, 0);
    send_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, NW, -1, 0);
    drain();

    // Downstream stall of 3 cycles right after limb 1.
    send_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, NW, 1, 0);
    drain();

    // Reset after limb 2, then a fresh operation starting at limb 0.
    send_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 3, -1, 0);
    pulse_reset();
    send_op(64'h1, 64'h2, 1'b0, NW, -1, 0);
    drain();

    // Two operations back to back at one limb per cycle.
    acc_log.delete();
    send_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, NW, -1, 0);
    send_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, NW, -1, 0);
    check_val("b2b_limbs", acc_log.size(), 2 * NW);
    if (acc_log.size() == 2 * NW)
      check_val("b2b_cycles", acc_log[2*NW-1] - acc_log[0], 2 * NW - 1);
    drain();

    // Random operands, random downstream backpressure and input gaps.
    rnd_bp = 1;
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: a = {1'b1, {(W-1){1'b0}}};
        1: b = {W{1'b1}};
        2: b = a;
        default: ;
      endcase
      send_op(a, b, 1'($urandom_range(0, 1)), NW, -1, 1);
    end
    rnd_bp = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
